// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetches via T0-T2, decodes the latched opcode and
// steps the execute states T3-T6, driving every datapath strobe from state alone.
module control_sequencer #(
  parameter int          OP_LSB  = 27,
  parameter logic [4:0]  ALU_ADD = 5'b00011
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  output logic        PCout,
  output logic        ZLowout,
  output logic        ZHighout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        InPortout,
  output logic        Cout,
  output logic        BAout,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        MDR_read,
  output logic        IR_enable,
  output logic        Y_enable,
  output logic        PC_enable,
  output logic        ZLowIn,
  output logic        ZHighIn,
  output logic        HI_enable,
  output logic        LO_enable,
  output logic        IncPC,
  output logic        CON_enable,
  output logic        OutPort_enable,
  output logic        RAM_write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        R_in,
  output logic        R_out,
  output logic [4:0]  alu_op,
  output logic        Run
);

  typedef enum logic [3:0] {S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT} state_t;

  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_HALT = 5'b11010;

  state_t     state, next_state;
  logic [4:0] opcode;
  logic [4:0] ir_op;
  logic       stop_req;
  logic       ir_unused;

  assign ir_op     = IR[OP_LSB+4:OP_LSB];
  assign ir_unused = ^IR;

  function automatic logic is_alu(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic is_multi(input logic [4:0] op);
    return is_alu(op) || (op == OP_LDI) || (op == OP_MUL) || (op == OP_BR);
  endfunction

  function automatic logic is_single(input logic [4:0] op);
    return (op == OP_MFHI) || (op == OP_MFLO) || (op == OP_IN) || (op == OP_OUT);
  endfunction

  // Stop is only honoured when seen on the edge leaving T0; the fetch still completes.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state    <= S_RST;
      opcode   <= '0;
      stop_req <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_T0) stop_req <= Stop;
      if (state == S_T2) opcode <= ir_op;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_RST:  next_state = S_T0;
      S_T0:   next_state = S_T1;
      S_T1:   next_state = S_T2;
      S_T2: begin
        if (stop_req || ir_op == OP_HALT)            next_state = S_HALT;
        else if (is_single(ir_op) || is_multi(ir_op)) next_state = S_T3;
        else                                          next_state = S_T0;
      end
      S_T3:   next_state = is_multi(opcode) ? S_T4 : S_T0;
      S_T4:   next_state = S_T5;
      S_T5: begin
        if (opcode == OP_MUL || (opcode == OP_BR && CON_FF)) next_state = S_T6;
        else                                                 next_state = S_T0;
      end
      S_T6:   next_state = S_T0;
      S_HALT: next_state = S_HALT;
      default: next_state = S_RST;
    endcase
  end

  always_comb begin
    PCout = 1'b0; ZLowout = 1'b0; ZHighout = 1'b0; MDRout = 1'b0; HIout = 1'b0;
    LOout = 1'b0; InPortout = 1'b0; Cout = 1'b0; BAout = 1'b0;
    MAR_enable = 1'b0; MDR_enable = 1'b0; MDR_read = 1'b0; IR_enable = 1'b0;
    Y_enable = 1'b0; PC_enable = 1'b0; ZLowIn = 1'b0; ZHighIn = 1'b0;
    HI_enable = 1'b0; LO_enable = 1'b0;
    IncPC = 1'b0; CON_enable = 1'b0; OutPort_enable = 1'b0; RAM_write = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; R_in = 1'b0; R_out = 1'b0;
    alu_op = '0;
    Run = (state != S_RST) && (state != S_HALT);
    case (state)
      S_T0: begin PCout = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1; end
      S_T1: begin ZLowout = 1'b1; PC_enable = 1'b1; MDR_read = 1'b1; MDR_enable = 1'b1; end
      S_T2: begin MDRout = 1'b1; IR_enable = 1'b1; end
      S_T3: begin
        case (opcode)
          OP_MFHI: begin Gra = 1'b1; R_in = 1'b1; HIout = 1'b1; end
          OP_MFLO: begin Gra = 1'b1; R_in = 1'b1; LOout = 1'b1; end
          OP_IN:   begin Gra = 1'b1; R_in = 1'b1; InPortout = 1'b1; end
          OP_OUT:  begin Gra = 1'b1; R_out = 1'b1; OutPort_enable = 1'b1; end
          OP_LDI:  begin Grb = 1'b1; BAout = 1'b1; Y_enable = 1'b1; end
          OP_MUL:  begin Gra = 1'b1; R_out = 1'b1; Y_enable = 1'b1; end
          OP_BR:   begin Gra = 1'b1; R_out = 1'b1; CON_enable = 1'b1; end
          default: if (is_alu(opcode)) begin Grb = 1'b1; R_out = 1'b1; Y_enable = 1'b1; end
        endcase
      end
      S_T4: begin
        case (opcode)
          OP_LDI:  begin Cout = 1'b1; ZLowIn = 1'b1; alu_op = ALU_ADD; end
          OP_MUL:  begin Grb = 1'b1; R_out = 1'b1; ZLowIn = 1'b1; ZHighIn = 1'b1; alu_op = opcode; end
          OP_BR:   begin PCout = 1'b1; Y_enable = 1'b1; end
          default: if (is_alu(opcode)) begin Grc = 1'b1; R_out = 1'b1; ZLowIn = 1'b1; alu_op = opcode; end
        endcase
      end
      S_T5: begin
        case (opcode)
          OP_MUL:  begin ZLowout = 1'b1; LO_enable = 1'b1; end
          OP_BR:   begin Cout = 1'b1; ZLowIn = 1'b1; alu_op = ALU_ADD; end
          default: if (is_alu(opcode) || opcode == OP_LDI) begin ZLowout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
        endcase
      end
      S_T6: begin
        if (opcode == OP_MUL) begin ZHighout = 1'b1; HI_enable = 1'b1; end
        else if (opcode == OP_BR) begin ZLowout = 1'b1; PC_enable = 1'b1; end
      end
      default: ;
    endcase
  end

endmodule
